// File: rtl/seg7_pkg.sv
// Shared seven-segment patterns and BCD helpers for the scan counter.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied by the user.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_D0    = 7'h3F;
    localparam logic [6:0] SEG_D1    = 7'h06;
    localparam logic [6:0] SEG_D2    = 7'h5B;
    localparam logic [6:0] SEG_D3    = 7'h4F;
    localparam logic [6:0] SEG_D4    = 7'h66;
    localparam logic [6:0] SEG_D5    = 7'h6D;
    localparam logic [6:0] SEG_D6    = 7'h7D;
    localparam logic [6:0] SEG_D7    = 7'h07;
    localparam logic [6:0] SEG_D8    = 7'h7F;
    localparam logic [6:0] SEG_D9    = 7'h6F;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'd0:    pat = SEG_D0;
            4'd1:    pat = SEG_D1;
            4'd2:    pat = SEG_D2;
            4'd3:    pat = SEG_D3;
            4'd4:    pat = SEG_D4;
            4'd5:    pat = SEG_D5;
            4'd6:    pat = SEG_D6;
            4'd7:    pat = SEG_D7;
            4'd8:    pat = SEG_D8;
            4'd9:    pat = SEG_D9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Non-decimal load nibbles clamp to 9.
    function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
        return (nibble > 4'd9) ? 4'd9 : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain; cin means "this digit steps this cycle",
// cout means the step ripples into the next digit.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       up_dn,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [3:0] digit_r;
    logic [3:0] next_s;

    // next digit value: clear beats load beats carry/borrow step
    always_comb begin
        next_s = digit_r;
        if (clr) begin
            next_s = 4'd0;
        end else if (load) begin
            next_s = bcd_sat(load_val);
        end else if (cin) begin
            if (up_dn) begin
                next_s = (digit_r == 4'd9) ? 4'd0 : digit_r + 4'd1;
            end else begin
                next_s = (digit_r == 4'd0) ? 4'd9 : digit_r - 4'd1;
            end
        end else begin
            next_s = digit_r;
        end
    end

    // digit storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_r <= 4'd0;
        end else begin
            digit_r <= next_s;
        end
    end

    assign digit = digit_r;
    assign cout  = cin & (up_dn ? (digit_r == 4'd9) : (digit_r == 4'd0));

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit up/down BCD counter with a time-multiplexed seven-segment driver.
// Counting and scanning run from independent prescalers; display outputs are registered.
module bcd_scan_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int TICK_DIV       = 100000,
    parameter int SCAN_DIV       = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int COM_ACTIVE_LOW = 1,
    parameter int LZ_BLANK       = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] bcd,
    output logic                wrap,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   segcom
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]     SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] COM_OFF   = (COM_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [TW-1:0]       tick_r;
    logic [SW-1:0]       scan_r;
    logic [IW-1:0]       idx_r;
    logic                step_s;
    logic [DIGITS:0]     carry_s;
    logic [4*DIGITS-1:0] bcd_s;
    logic                wrap_r;
    logic [DIGITS:0]     lead_s;
    logic [3:0]          nib_s;
    logic                blank_s;
    logic [DIGITS-1:0]   com_s;
    logic [6:0]          pat_s;
    logic [6:0]          seg_r;
    logic [DIGITS-1:0]   segcom_r;

    assign step_s     = en & (tick_r == TICK_LAST);
    assign carry_s[0] = step_s;

    // tick prescaler: restarts on clear/load, advances only while enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_r <= '0;
        end else if (clr || load) begin
            tick_r <= '0;
        end else if (en) begin
            tick_r <= (tick_r == TICK_LAST) ? '0 : tick_r + TW'(1);
        end else begin
            tick_r <= tick_r;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .reset    (reset),
            .clr      (clr),
            .load     (load),
            .load_val (load_val[4*g +: 4]),
            .up_dn    (up_dn),
            .cin      (carry_s[g]),
            .digit    (bcd_s[4*g +: 4]),
            .cout     (carry_s[g+1])
        );
    end

    // wrap pulses only when a real step ripples out of the top digit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= step_s & ~clr & ~load & carry_s[DIGITS];
        end
    end

    // free-running scan prescaler and digit index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_r <= '0;
            idx_r  <= '0;
        end else if (scan_r == SCAN_LAST) begin
            scan_r <= '0;
            idx_r  <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
        end else begin
            scan_r <= scan_r + SW'(1);
            idx_r  <= idx_r;
        end
    end

    // lead_s[i]: nibble i and every higher nibble are zero (bit DIGITS is a sentinel, bit 0 never blanks)
    always_comb begin
        lead_s         = '0;
        lead_s[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead_s[i] = lead_s[i+1] & (bcd_s[4*i +: 4] == 4'd0);
        end
    end

    // select the strobed digit, its common and its pattern
    always_comb begin
        nib_s   = 4'd0;
        blank_s = 1'b0;
        com_s   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IW'(i)) begin
                nib_s    = bcd_s[4*i +: 4];
                blank_s  = (LZ_BLANK != 0) && lead_s[i];
                com_s[i] = 1'b1;
            end else begin
                com_s[i] = 1'b0;
            end
        end
        pat_s = blank_s ? SEG_BLANK : seg7_decode(nib_s);
    end

    // registered display outputs with pin polarity applied
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_r    <= SEG_OFF;
            segcom_r <= COM_OFF;
        end else begin
            seg_r    <= (SEG_ACTIVE_LOW != 0) ? ~pat_s : pat_s;
            segcom_r <= (COM_ACTIVE_LOW != 0) ? ~com_s : com_s;
        end
    end

    assign bcd    = bcd_s;
    assign wrap   = wrap_r;
    assign seg    = seg_r;
    assign segcom = segcom_r;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter (DIGITS=4, TICK_DIV=4, SCAN_DIV=2, active-low),
// with a second LZ_BLANK=1 instance sharing the same stimulus.
module tb_bcd_scan_counter;

    localparam int SEL_BCD = 0, SEL_WRAP = 1, SEL_SEG = 2, SEL_COM = 3, SEL_LZSEG = 4, SEL_LZCOM = 5;

    typedef struct {
        int          at;
        int          sel;
        logic [15:0] val;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, en, up_dn, clr, load;
    logic [15:0] load_val;
    logic [15:0] bcd, lz_bcd;
    logic        wrap, lz_wrap;
    logic [6:0]  seg, lz_seg;
    logic [3:0]  segcom, lz_segcom;

    exp_t q[$];
    int   ncnt = 0;
    int   checks = 0;
    int   failures = 0;

    bcd_scan_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1),
                       .COM_ACTIVE_LOW(1), .LZ_BLANK(0)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .bcd(bcd), .wrap(wrap), .seg(seg), .segcom(segcom));

    bcd_scan_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1),
                       .COM_ACTIVE_LOW(1), .LZ_BLANK(1)) dut_lz (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .bcd(lz_bcd), .wrap(lz_wrap), .seg(lz_seg), .segcom(lz_segcom));

    always #5 clk = ~clk;

    function automatic logic [15:0] actual(input int sel);
        case (sel)
            SEL_BCD:   return bcd;
            SEL_WRAP:  return {15'd0, wrap};
            SEL_SEG:   return {9'd0, seg};
            SEL_COM:   return {12'd0, segcom};
            SEL_LZSEG: return {9'd0, lz_seg};
            SEL_LZCOM: return {12'd0, lz_segcom};
            default:   return 16'hDEAD;
        endcase
    endfunction

    // Strobed digit at a given negedge count: release is at negedge 3, index advances every 2 clocks.
    function automatic int scan_idx(input int at);
        return ((at - 4) / 2) % 4;
    endfunction

    function automatic logic [15:0] com_exp(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return {12'd0, ~(one << idx)};
    endfunction

    task automatic exp_at(input int k, input int sel, input logic [15:0] v, input string nm);
        exp_t e;
        e.at = ncnt + k; e.sel = sel; e.val = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // monitor: compares every expectation that falls due on this negedge
    initial begin
        logic [15:0] act;
        forever begin
            @(negedge clk);
            ncnt = ncnt + 1;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].at == ncnt) begin
                    act = actual(q[i].sel);
                    checks = checks + 1;
                    if (act !== q[i].val) begin
                        failures = failures + 1;
                        $display("FAIL %s cycle=%0d got=%h expected=%h", q[i].nm, ncnt, act, q[i].val);
                    end
                    q.delete(i);
                end
            end
        end
    end

    initial begin
        int at;
        reset = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 16'h0000;

        // 1. reset values, then idle scanning of "0000"
        exp_at(1, SEL_BCD, 16'h0000, "rst_bcd");
        exp_at(1, SEL_WRAP, 16'h0000, "rst_wrap");
        exp_at(1, SEL_SEG, 16'h007F, "rst_seg");
        exp_at(2, SEL_COM, 16'h000F, "rst_com");
        exp_at(3, SEL_LZCOM, 16'h000F, "rst_lzcom");
        step_n(3);
        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            at = ncnt + k;
            exp_at(k, SEL_COM, com_exp(scan_idx(at)), "scan_com");
            exp_at(k, SEL_SEG, 16'h0040, "scan_seg0");
        end
        exp_at(20, SEL_BCD, 16'h0000, "idle_bcd");
        step_n(20);

        // 2. count up from zero, one step every 4 clocks
        en = 1'b1; up_dn = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            exp_at(4 * j, SEL_BCD, (j < 10) ? 16'(j) : 16'h0010, "up_bcd");
            exp_at(4 * j, SEL_WRAP, 16'h0000, "up_nowrap");
        end
        step_n(40);

        // 3a. roll-over 9999 -> 0000
        en = 1'b0; load = 1'b1; load_val = 16'h9999;
        exp_at(1, SEL_BCD, 16'h9999, "load9999");
        step_n(1);
        load = 1'b0; en = 1'b1;
        exp_at(3, SEL_BCD, 16'h9999, "ovf_pre_bcd");
        exp_at(3, SEL_WRAP, 16'h0000, "ovf_pre_wrap");
        exp_at(4, SEL_BCD, 16'h0000, "ovf_bcd");
        exp_at(4, SEL_WRAP, 16'h0001, "ovf_wrap");
        exp_at(5, SEL_WRAP, 16'h0000, "ovf_wrap_end");
        step_n(5);

        // 3b. roll-under 0000 -> 9999
        en = 1'b0; load = 1'b1; load_val = 16'h0000; up_dn = 1'b0;
        exp_at(1, SEL_BCD, 16'h0000, "load0000");
        step_n(1);
        load = 1'b0; en = 1'b1;
        exp_at(3, SEL_WRAP, 16'h0000, "unf_pre_wrap");
        exp_at(4, SEL_BCD, 16'h9999, "unf_bcd");
        exp_at(4, SEL_WRAP, 16'h0001, "unf_wrap");
        exp_at(5, SEL_WRAP, 16'h0000, "unf_wrap_end");
        exp_at(5, SEL_BCD, 16'h9999, "unf_bcd_hold");
        step_n(5);

        // 4. load saturation, clr over load, clr held against en
        en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 16'h1AF9;
        exp_at(1, SEL_BCD, 16'h1999, "load_sat");
        step_n(1);
        clr = 1'b1; load_val = 16'h1234;
        exp_at(1, SEL_BCD, 16'h0000, "clr_over_load");
        step_n(1);
        load = 1'b0; en = 1'b1;
        exp_at(4, SEL_BCD, 16'h0000, "clr_held4");
        exp_at(4, SEL_WRAP, 16'h0000, "clr_nowrap");
        exp_at(10, SEL_BCD, 16'h0000, "clr_held10");
        step_n(10);

        // 5. leading-zero blanking on 0012
        clr = 1'b0; en = 1'b0; load = 1'b1; load_val = 16'h0012;
        step_n(1);
        load = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            at = ncnt + k;
            case (scan_idx(at))
                0: begin
                    exp_at(k, SEL_LZSEG, 16'h0024, "lz_d0");
                    exp_at(k, SEL_SEG, 16'h0024, "d0_two");
                end
                1: begin
                    exp_at(k, SEL_LZSEG, 16'h0079, "lz_d1");
                    exp_at(k, SEL_SEG, 16'h0079, "d1_one");
                end
                default: begin
                    exp_at(k, SEL_LZSEG, 16'h007F, "lz_blank");
                    exp_at(k, SEL_SEG, 16'h0040, "noblank_zero");
                end
            endcase
            exp_at(k, SEL_LZCOM, com_exp(scan_idx(at)), "lz_com");
        end
        step_n(8);

        // 6. asynchronous reset mid-count
        load = 1'b1; load_val = 16'h0457;
        step_n(1);
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        exp_at(2, SEL_BCD, 16'h0457, "pre_rst_bcd");
        step_n(2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_at(1, SEL_BCD, 16'h0000, "async_bcd");
        exp_at(1, SEL_COM, 16'h000F, "async_com");
        exp_at(1, SEL_SEG, 16'h007F, "async_seg");
        exp_at(1, SEL_WRAP, 16'h0000, "async_wrap");
        exp_at(1, SEL_LZSEG, 16'h007F, "async_lzseg");
        step_n(2);
        reset = 1'b1;
        exp_at(1, SEL_COM, 16'h000E, "restart_com0");
        exp_at(2, SEL_COM, 16'h000E, "restart_com0b");
        exp_at(3, SEL_COM, 16'h000D, "restart_com1");
        exp_at(3, SEL_BCD, 16'h0000, "restart_bcd0");
        exp_at(4, SEL_BCD, 16'h0001, "restart_bcd1");
        step_n(6);

        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL pending_expectations got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
